// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: op codes, ALU select codes and
// helpers that give each op's entry requirements.
package stack_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_BIN   = 3'b011;
    localparam logic [2:0] OP_UNARY = 3'b100;
    localparam logic [2:0] OP_PAIR  = 3'b101;
    localparam logic [2:0] OP_DUP   = 3'b110;
    localparam logic [2:0] OP_RSV   = 3'b111;

    // ALU function selects; the decoder pairs BIN with the binary/compare
    // codes, UNARY with ALU_NOT and PAIR with ALU_SWAP/ALU_DIVMOD.
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_MUL    = 4'd2,
        ALU_AND    = 4'd3,
        ALU_OR     = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_LT     = 4'd6,
        ALU_EQ     = 4'd7,
        ALU_NOT    = 4'd8,
        ALU_SWAP   = 4'd9,
        ALU_DIVMOD = 4'd10
    } alu_sel_e;

    function automatic logic [1:0] op_min_depth(input logic [2:0] op);
        case (op)
            OP_POP, OP_UNARY, OP_DUP: op_min_depth = 2'd1;
            OP_BIN, OP_PAIR:          op_min_depth = 2'd2;
            default:                  op_min_depth = 2'd0;
        endcase
    endfunction

    function automatic logic op_is_push(input logic [2:0] op);
        op_is_push = (op == OP_PUSH) || (op == OP_DUP);
    endfunction

endpackage

// File: rtl/stack_spill_ram.sv
// Register-array backing store for stack entries below next.
// Synchronous write, combinational read, no reset.
module stack_spill_ram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack.sv
// Operand stack: tos/next held in registers feeding the ALU, deeper entries
// spilled to stack_spill_ram. One op per cycle, illegal ops suppressed.
module data_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 16,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] push_data,
    input  logic [WIDTH-1:0] alu_tos,
    input  logic [WIDTH-1:0] alu_next,
    input  logic             err_clr,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] next,
    output logic [PTR_W:0]   depth,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] CAP = (PTR_W+1)'(DEPTH + 2);

    logic [WIDTH-1:0] tos_q, tos_d, next_q, next_d;
    logic [PTR_W:0]   depth_q, depth_d;
    logic [PTR_W-1:0] sp_q, sp_d;
    logic             ovf_q, unf_q;
    logic             ovf_err, unf_err, op_ok;
    logic             has_next, has_spill;
    logic             spill_we;
    logic [WIDTH-1:0] spill_rdata;

    assign full  = (depth_q == CAP);
    assign empty = (depth_q == '0);

    assign has_next  = (depth_q >= (PTR_W+1)'(2));
    assign has_spill = (depth_q >= (PTR_W+1)'(3));

    // Overflow takes priority; a push-type op can never also be short of entries
    // while full, so the two error terms are mutually exclusive in practice.
    assign ovf_err = op_valid && op_is_push(op) && full;
    assign unf_err = op_valid && !ovf_err && (depth_q < (PTR_W+1)'(op_min_depth(op)));
    assign op_ok   = op_valid && !ovf_err && !unf_err;

    always_comb begin
        tos_d    = tos_q;
        next_d   = next_q;
        depth_d  = depth_q;
        sp_d     = sp_q;
        spill_we = 1'b0;
        if (op_ok) begin
            case (op)
                OP_PUSH, OP_DUP: begin
                    if (op == OP_PUSH) begin
                        tos_d = push_data;
                    end
                    next_d   = tos_q;
                    spill_we = has_next;
                    depth_d  = depth_q + (PTR_W+1)'(1);
                    if (has_next) begin
                        sp_d = sp_q + PTR_W'(1);
                    end
                end
                OP_POP, OP_BIN: begin
                    if (op == OP_POP) begin
                        tos_d = has_next ? next_q : '0;
                    end else begin
                        tos_d = alu_tos;
                    end
                    next_d  = has_spill ? spill_rdata : '0;
                    depth_d = depth_q - (PTR_W+1)'(1);
                    if (has_spill) begin
                        sp_d = sp_q - PTR_W'(1);
                    end
                end
                OP_UNARY: tos_d = alu_tos;
                OP_PAIR: begin
                    tos_d  = alu_tos;
                    next_d = alu_next;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos_q   <= '0;
            next_q  <= '0;
            depth_q <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            next_q  <= next_d;
            depth_q <= depth_d;
            sp_q    <= sp_d;
            // A new error in the same cycle as err_clr leaves the flag set.
            ovf_q   <= (ovf_q && !err_clr) || ovf_err;
            unf_q   <= (unf_q && !err_clr) || unf_err;
        end
    end

    stack_spill_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_spill (
        .clk   (clk),
        .we    (spill_we),
        .waddr (AW'(sp_q)),
        .wdata (next_q),
        .raddr (AW'(sp_q - PTR_W'(1))),
        .rdata (spill_rdata)
    );

    assign tos       = tos_q;
    assign next      = next_q;
    assign depth     = depth_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: directed scenarios plus random ops
// compared against a queue-based stack model.
module tb_data_stack;

    localparam int W   = 16;
    localparam int CAP = 18;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, BIN = 3'd3,
                           UNARY = 3'd4, PAIR = 3'd5, DUP = 3'd6, RSV = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op_valid;
    logic [2:0]   op;
    logic [W-1:0] push_data, alu_tos, alu_next;
    logic         err_clr;
    logic [W-1:0] tos, next;
    logic [5:0]   depth;
    logic         full, empty, overflow, underflow;

    int checks = 0;
    int failures = 0;

    // Model: queue front is the top of stack.
    logic [W-1:0] mq[$];
    logic         m_ovf, m_unf;

    data_stack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op        (op),
        .push_data (push_data),
        .alu_tos   (alu_tos),
        .alu_next  (alu_next),
        .err_clr   (err_clr),
        .tos       (tos),
        .next      (next),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic model_apply(input logic v, input logic [2:0] o, input logic [W-1:0] pd,
                               input logic [W-1:0] at, input logic [W-1:0] an, input logic c);
        int req;
        logic [W-1:0] tmp;
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (v) begin
            req = (o == POP || o == UNARY || o == DUP) ? 1 : (o == BIN || o == PAIR) ? 2 : 0;
            if ((o == PUSH || o == DUP) && mq.size() == CAP) m_ovf = 1'b1;
            else if (mq.size() < req) m_unf = 1'b1;
            else begin
                case (o)
                    PUSH:  mq.push_front(pd);
                    POP:   tmp = mq.pop_front();
                    BIN:   begin tmp = mq.pop_front(); mq[0] = at; end
                    UNARY: mq[0] = at;
                    PAIR:  begin mq[0] = at; mq[1] = an; end
                    DUP:   mq.push_front(mq[0]);
                    default: ;
                endcase
            end
        end
    endtask

    function automatic logic [41:0] model_state();
        logic [W-1:0] t, n;
        t = (mq.size() >= 1) ? mq[0] : '0;
        n = (mq.size() >= 2) ? mq[1] : '0;
        model_state = {t, n, 6'(mq.size()), mq.size() == CAP, mq.size() == 0, m_ovf, m_unf};
    endfunction

    // Called on a falling edge; returns on the next falling edge.
    task automatic step(input logic v, input logic [2:0] o, input logic [W-1:0] pd,
                        input logic [W-1:0] at, input logic [W-1:0] an, input logic c);
        op_valid = v; op = o; push_data = pd; alu_tos = at; alu_next = an; err_clr = c;
        @(posedge clk);
        model_apply(v, o, pd, at, an, c);
        @(negedge clk);
        op_valid = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({tos, next, depth, full, empty, overflow, underflow} !== {16'h0, 16'h0, 6'd0, 4'b0100}) begin
            failures++;
            $display("FAIL reset_state: got tos=%h next=%h depth=%0d full=%b empty=%b ovf=%b unf=%b, want all zero with empty=1",
                     tos, next, depth, full, empty, overflow, underflow);
        end
    endtask

    task automatic test_push_bin();
        step(1, PUSH, 16'h0003, 16'hx, 16'hx, 0);
        step(1, PUSH, 16'h0005, 16'hx, 16'hx, 0);
        checks++;
        if ({tos, next, depth} !== {16'h0005, 16'h0003, 6'd2}) begin
            failures++;
            $display("FAIL push2: got tos=%h next=%h depth=%0d, want 0005 0003 2", tos, next, depth);
        end
        step(1, BIN, 16'h0, 16'h0008, 16'h0, 0);
        checks++;
        if ({tos, next, depth, overflow, underflow} !== {16'h0008, 16'h0000, 6'd1, 2'b00}) begin
            failures++;
            $display("FAIL bin_shallow: got tos=%h next=%h depth=%0d ovf=%b unf=%b, want 0008 0000 1 0 0",
                     tos, next, depth, overflow, underflow);
        end
        step(1, POP, 16'h0, 16'h0, 16'h0, 0);
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= CAP; i++) step(1, PUSH, 16'(i), 16'h0, 16'h0, 0);
        checks++;
        if ({full, tos, depth} !== {1'b1, 16'h0012, 6'd18}) begin
            failures++;
            $display("FAIL fill: got full=%b tos=%h depth=%0d, want 1 0012 18", full, tos, depth);
        end
        step(1, PUSH, 16'hFFFF, 16'h0, 16'h0, 0);
        checks++;
        if ({tos, next, depth, overflow, underflow} !== {16'h0012, 16'h0011, 6'd18, 2'b10}) begin
            failures++;
            $display("FAIL overflow_push: got tos=%h next=%h depth=%0d ovf=%b unf=%b, want 0012 0011 18 1 0",
                     tos, next, depth, overflow, underflow);
        end
        step(1, DUP, 16'h0, 16'h0, 16'h0, 0);
        checks++;
        if ({tos, depth, overflow, underflow} !== {16'h0012, 6'd18, 2'b10}) begin
            failures++;
            $display("FAIL overflow_dup: got tos=%h depth=%0d ovf=%b unf=%b, want 0012 18 1 0",
                     tos, depth, overflow, underflow);
        end
        for (int i = CAP; i >= 1; i--) begin
            checks++;
            if (tos !== 16'(i)) begin
                failures++;
                $display("FAIL drain_order: got tos=%h, want %h", tos, 16'(i));
            end
            step(1, POP, 16'h0, 16'h0, 16'h0, 0);
        end
        checks++;
        if ({empty, depth, tos, next} !== {1'b1, 6'd0, 16'h0, 16'h0}) begin
            failures++;
            $display("FAIL drained_empty: got empty=%b depth=%0d tos=%h next=%h, want 1 0 0000 0000",
                     empty, depth, tos, next);
        end
        step(0, NOP, 16'h0, 16'h0, 16'h0, 1);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got overflow=%b, want 0", overflow);
        end
    endtask

    task automatic test_underflow_clr();
        step(1, POP, 16'h0, 16'h0, 16'h0, 0);
        checks++;
        if ({underflow, overflow, depth, tos} !== {2'b10, 6'd0, 16'h0}) begin
            failures++;
            $display("FAIL pop_empty: got unf=%b ovf=%b depth=%0d tos=%h, want 1 0 0 0000",
                     underflow, overflow, depth, tos);
        end
        step(0, NOP, 16'h0, 16'h0, 16'h0, 1);
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL unf_clear: got underflow=%b, want 0", underflow);
        end
        step(1, POP, 16'h0, 16'h0, 16'h0, 1);
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL clr_set_wins: got underflow=%b, want 1", underflow);
        end
        step(1, DUP, 16'h0, 16'h0, 16'h0, 1);
        checks++;
        if ({underflow, overflow, depth} !== {2'b10, 6'd0}) begin
            failures++;
            $display("FAIL dup_empty: got unf=%b ovf=%b depth=%0d, want 1 0 0", underflow, overflow, depth);
        end
        step(1, RSV, 16'h0, 16'h0, 16'h0, 1);
        checks++;
        if ({underflow, overflow, depth} !== {2'b00, 6'd0}) begin
            failures++;
            $display("FAIL reserved_op: got unf=%b ovf=%b depth=%0d, want 0 0 0", underflow, overflow, depth);
        end
    endtask

    task automatic test_pair_bin();
        step(1, PUSH, 16'h000A, 16'h0, 16'h0, 0);
        step(1, PUSH, 16'h000B, 16'h0, 16'h0, 0);
        step(1, PUSH, 16'h000C, 16'h0, 16'h0, 0);
        step(1, PAIR, 16'h0, 16'h000B, 16'h000C, 0);
        checks++;
        if ({tos, next, depth} !== {16'h000B, 16'h000C, 6'd3}) begin
            failures++;
            $display("FAIL pair: got tos=%h next=%h depth=%0d, want 000B 000C 3", tos, next, depth);
        end
        step(1, BIN, 16'h0, 16'h0017, 16'h0, 0);
        checks++;
        if ({tos, next, depth} !== {16'h0017, 16'h000A, 6'd2}) begin
            failures++;
            $display("FAIL bin_spill: got tos=%h next=%h depth=%0d, want 0017 000A 2", tos, next, depth);
        end
        step(1, POP, 16'h0, 16'h0, 16'h0, 0);
        step(1, POP, 16'h0, 16'h0, 16'h0, 0);
    endtask

    task automatic test_dup_unary();
        step(1, PUSH, 16'h1234, 16'h0, 16'h0, 0);
        step(1, DUP, 16'h0, 16'h0, 16'h0, 0);
        checks++;
        if ({tos, next, depth} !== {16'h1234, 16'h1234, 6'd2}) begin
            failures++;
            $display("FAIL dup: got tos=%h next=%h depth=%0d, want 1234 1234 2", tos, next, depth);
        end
        step(1, UNARY, 16'h0, 16'hEDCB, 16'h0, 0);
        checks++;
        if ({tos, next, depth} !== {16'hEDCB, 16'h1234, 6'd2}) begin
            failures++;
            $display("FAIL unary: got tos=%h next=%h depth=%0d, want EDCB 1234 2", tos, next, depth);
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [41:0] exp_s;
        for (int i = 0; i < 600; i++) begin
            o = ($urandom_range(0, 9) < 3) ? PUSH : 3'($urandom_range(0, 7));
            step($urandom_range(0, 9) != 0, o, 16'($urandom), 16'($urandom), 16'($urandom),
                 $urandom_range(0, 15) == 0);
            exp_s = model_state();
            checks++;
            if ({tos, next, depth, full, empty, overflow, underflow} !== exp_s) begin
                failures++;
                $display("FAIL random_op%0d: got tos=%h next=%h depth=%0d f/e/o/u=%b%b%b%b, want %h %h %0d %b",
                         i, tos, next, depth, full, empty, overflow, underflow,
                         exp_s[41:26], exp_s[25:10], exp_s[9:4], exp_s[3:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        step(0, NOP, 16'h0, 16'h0, 16'h0, 1);
        while (mq.size() > 0) step(1, POP, 16'h0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 5; i++) step(1, PUSH, 16'(16'h0100 + i), 16'h0, 16'h0, 0);
        step(1, POP, 16'h0, 16'h0, 16'h0, 1);
        step(1, POP, 16'h0, 16'h0, 16'h0, 0);
        step(1, POP, 16'h0, 16'h0, 16'h0, 0);
        step(1, POP, 16'h0, 16'h0, 16'h0, 0);
        step(1, POP, 16'h0, 16'h0, 16'h0, 0);
        step(1, POP, 16'h0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 5; i++) step(1, PUSH, 16'(16'h0200 + i), 16'h0, 16'h0, 0);
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        checks++;
        if ({tos, next, depth, overflow, underflow} !== {16'h0, 16'h0, 6'd0, 2'b00}) begin
            failures++;
            $display("FAIL async_reset: got tos=%h next=%h depth=%0d ovf=%b unf=%b, want all zero",
                     tos, next, depth, overflow, underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1, PUSH, 16'h0007, 16'h0, 16'h0, 0);
        checks++;
        if ({tos, next, depth} !== {16'h0007, 16'h0000, 6'd1}) begin
            failures++;
            $display("FAIL post_reset_push: got tos=%h next=%h depth=%0d, want 0007 0000 1", tos, next, depth);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        op_valid = 1'b0; op = NOP; push_data = '0; alu_tos = '0; alu_next = '0; err_clr = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_push_bin();
        test_fill_drain();
        test_underflow_clr();
        test_pair_bin();
        test_dup_unary();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_stack.md
Name: data_stack

Overview:
- Operand stack that feeds the ALU and takes back its results.
- Holds the two top entries in registers. tos and next drive the ALU tos/next inputs directly.
- Deeper entries spill into a register-array stack.
- Each cycle, the decoder issues one stack op, and this block applies it using push data or the ALU results o_tos/o_next.

Parameters:
- WIDTH, 16, data word width; must match the ALU.
- DEPTH, 16, number of spill entries below next; total capacity is DEPTH+2.
- PTR_W, 5, spill pointer width; must satisfy 2^PTR_W > DEPTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  op is applied this cycle when high.
- op  in  3  stack operation code; see Behaviour.
- push_data  in  WIDTH  literal/load value for PUSH.
- alu_tos  in  WIDTH  ALU o_tos result.
- alu_next  in  WIDTH  ALU o_next result.
- err_clr  in  1  clears both sticky error flags.
- tos  out  WIDTH  top-of-stack register, to ALU tos.
- next  out  WIDTH  second-entry register, to ALU next.
- depth  out  PTR_W+1  number of valid entries, 0..DEPTH+2.
- full  out  1  depth == DEPTH+2, combinational from depth.
- empty  out  1  depth == 0, combinational from depth.
- overflow  out  1  sticky: a push-type op was issued while full.
- underflow  out  1  sticky: an op was issued with too few entries.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - tos=0, next=0, depth=0, spill pointer sp=0, overflow=0, underflow=0.
  - The spill array is not reset.
  - Reset mid-operation abandons the op.
- Timing:
  - All ops complete in one cycle; the result is visible on tos/next/depth the cycle after op_valid.
  - The ALU is combinational, so alu_tos/alu_next are sampled in the same cycle as the op.
- op encoding (requirement = minimum depth; push ops also need !full):
  - 000 NOP: no change.
  - 001 PUSH: tos<=push_data, next<=tos, spill[sp]<=next if depth>=2, depth+1. Requires !full.
  - 010 POP: tos<=next, next<=spill[sp-1] if depth>=3 else 0, depth-1. Requires >=1.
  - 011 BIN (add/sub/mul/logic/compare): tos<=alu_tos, next<=spill[sp-1] if depth>=3 else 0, depth-1. Requires >=2.
  - 100 UNARY (not): tos<=alu_tos, depth unchanged. Requires >=1.
  - 101 PAIR (swap, divmod): tos<=alu_tos, next<=alu_next, depth unchanged. Requires >=2.
  - 110 DUP: next<=tos, spill[sp]<=next if depth>=2, depth+1. Requires >=1 and !full.
  - 111: reserved; treated as NOP with no error.
- Spill rules:
  - sp = max(depth-2, 0).
  - A write to spill occurs only when the moved-down next is valid (depth>=2 before the op).
  - A read from spill occurs only when depth>=3 before the op; otherwise the vacated register loads 0.
  - Vacated tos (POP at depth 1) loads 0.
- Errors:
  - An op whose requirement fails is suppressed: no state changes except the flag.
  - Push-type op (PUSH/DUP) while full sets overflow.
  - Any op with insufficient depth sets underflow.
  - DUP on empty sets underflow only.
- Flag clearing:
  - err_clr clears both flags.
  - If err_clr and a new error occur in the same cycle, the flag ends set (set wins).
- op_valid low: op is ignored, and alu/push inputs are don't-care.
- Width: no arithmetic on data here. depth/sp arithmetic never wraps, because of the suppression above.

Decomposition:
- Shared package stack_pkg:
  - op codes OP_NOP..OP_DUP as localparams.
  - WIDTH default.
  - The ALU select codes, so the decoder can pair them.
- One sub-module, natural split: stack_spill_ram.
  - DEPTH x WIDTH register array.
  - Synchronous write (we, waddr, wdata); combinational read (raddr, rdata).
  - No reset.

Test Plan:
- Reset then PUSH 0x0003, PUSH 0x0005 -> tos=0x0005, next=0x0003, depth=2; then BIN with alu_tos=0x0008 -> tos=0x0008, next=0, depth=1, no flags.
- PUSH 0x0001..0x0012 (18 values, DEPTH=16) -> full=1, tos=0x0012; 19th PUSH 0xFFFF -> state unchanged, overflow=1. Then 18 POPs return 0x0012 down to 0x0001 in order, and empty=1.
- POP on empty -> underflow=1, depth=0, tos=0; err_clr with no error -> underflow=0; err_clr and POP on empty in the same cycle -> underflow=1.
- Depth 3 (0xA,0xB,0xC), PAIR with alu_tos=0x000B, alu_next=0x000C -> tos=0x000B, next=0x000C, depth=3; then BIN -> next=0x000A from spill, depth=2.
- DUP at depth 1 with tos=0x1234 -> tos=next=0x1234, depth=2; UNARY with alu_tos=0xEDCB -> tos=0xEDCB, next=0x1234.
- Push 5 values, then assert rst_n low mid-cycle (no clock edge) -> tos/next/depth/flags read 0 immediately; after release, the first PUSH 0x0007 -> depth=1, tos=0x0007.
